// File: rtl/axilprefetch_pkg.sv
// Shared AXI-lite constants for the instruction prefetch unit.
package axilprefetch_pkg;

   // Unprivileged, secure, instruction access.
   localparam logic [2:0] ARPROT_INSN  = 3'b100;
   localparam int         RRESP_ERR_BIT = 1;

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO with occupancy count; first-word data visible combinationally.
// Latency: write to non-empty 1 cycle; writes when full and reads when empty are ignored.
module sfifo #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_i,
   input  logic [BW-1:0]     data_i,
   output logic              full_o,
   output logic [LGFLEN:0]   fill_o,
   input  logic              rd_i,
   output logic [BW-1:0]     data_o,
   output logic              empty_o
);
   localparam int DEPTH = 2 ** LGFLEN;

   logic [BW-1:0]   mem_q [DEPTH];
   logic [LGFLEN:0] wptr_q, rptr_q;
   logic            do_wr, do_rd;

   assign fill_o  = wptr_q - rptr_q;
   assign full_o  = (fill_o == (LGFLEN+1)'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign do_wr   = wr_i && !full_o;
   assign do_rd   = rd_i && !empty_o;
   assign data_o  = mem_q[rptr_q[LGFLEN-1:0]];

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q[LGFLEN-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/axilprefetch.sv
// AXI-lite instruction prefetch: credit-limited reads, redirect drops stale responses, words unpacked to instructions.
// Latency: redirect->ARVALID 1 cycle, RVALID->o_valid 2 cycles; i_ready low holds o_insn and issue stops when credits run out.
module axilprefetch
   import axilprefetch_pkg::*;
#(
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_AXI_DATA_WIDTH = 64,
   parameter int INSN_WIDTH       = 32,
   parameter int LGFIFO           = 4,
   parameter bit SWAP_ENDIANNESS  = 1'b1
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        i_reset,
   input  logic                        i_new_pc,
   input  logic [C_AXI_ADDR_WIDTH-1:0] i_pc,
   input  logic                        i_ready,
   output logic                        o_valid,
   output logic [INSN_WIDTH-1:0]       o_insn,
   output logic [C_AXI_ADDR_WIDTH-1:0] o_pc,
   output logic                        o_illegal,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                  M_AXI_ARPROT,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP
);
   localparam int AW             = C_AXI_ADDR_WIDTH;
   localparam int DW             = C_AXI_DATA_WIDTH;
   localparam int IW             = INSN_WIDTH;
   localparam int AXILLSB        = $clog2(DW/8);
   localparam int INSN_LSB       = $clog2(IW/8);
   localparam int INSNS_PER_WORD = DW/IW;
   localparam int LW             = (INSNS_PER_WORD > 1) ? $clog2(INSNS_PER_WORD) : 1;
   localparam int CW             = LGFIFO + 1;
   localparam logic [CW-1:0] DEPTH     = CW'(2 ** LGFIFO);
   localparam logic [LW-1:0] LAST_LANE = LW'(INSNS_PER_WORD - 1);

   logic          arvalid_q, arvalid_d, ar_stale_q, ar_stale_d;
   logic [AW-1:0] araddr_q, araddr_d, tgt_q, tgt_d, pc_q, pc_d;
   logic [CW-1:0] live_q, live_d, stale_q, stale_d;
   logic          halted_q, halted_d, valid_q, valid_d, illegal_q, illegal_d;
   logic          first_q, first_d;
   logic [DW-1:0] word_q, word_d;
   logic [LW-1:0] lane_q, lane_d, off_q, off_d, pc_lane;

   logic          ar_hs, keep, drop, accept, last_lane, load, rd_en;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_fill, live_req;
   logic [DW:0]   fifo_rdata;
   logic [DW-1:0] rdata_sw;
   logic [AW-1:0] pc_aligned;
   logic [IW-1:0] lanes [INSNS_PER_WORD];

   generate
      for (genvar l = 0; l < INSNS_PER_WORD; l++) begin : g_lane
         for (genvar b = 0; b < IW/8; b++) begin : g_byte
            if (SWAP_ENDIANNESS) begin : g_sw
               assign rdata_sw[l*IW + b*8 +: 8] = M_AXI_RDATA[l*IW + (IW/8-1-b)*8 +: 8];
            end else begin : g_ns
               assign rdata_sw[l*IW + b*8 +: 8] = M_AXI_RDATA[l*IW + b*8 +: 8];
            end
         end
         assign lanes[l] = word_q[l*IW +: IW];
      end
      if (INSNS_PER_WORD > 1) begin : g_off
         assign pc_lane = i_pc[AXILLSB-1:INSN_LSB];
      end else begin : g_nooff
         assign pc_lane = '0;
      end
   endgenerate

   assign pc_aligned = {i_pc[AW-1:AXILLSB], {AXILLSB{1'b0}}};
   assign ar_hs      = arvalid_q && M_AXI_ARREADY;
   // Requests still on the bus whose data will be kept.
   assign live_req   = live_q - fifo_fill;
   assign drop       = M_AXI_RVALID && (stale_q != '0 || live_req != '0);
   assign keep       = M_AXI_RVALID && stale_q == '0 && live_req != '0 && !i_new_pc;
   assign accept     = valid_q && i_ready && !illegal_q;
   assign last_lane  = (lane_q == LAST_LANE);
   assign load       = !halted_q && !fifo_empty && (!valid_q || (accept && last_lane));
   assign rd_en      = load && !i_new_pc;

   sfifo #(.BW(DW+1), .LGFLEN(LGFIFO)) u_fifo (
      .clk_i   (S_AXI_ACLK),
      .reset_i (i_reset || i_new_pc),
      .wr_i    (keep),
      .data_i  ({M_AXI_RRESP[RRESP_ERR_BIT], rdata_sw}),
      .full_o  (fifo_full),
      .fill_o  (fifo_fill),
      .rd_i    (rd_en),
      .data_o  (fifo_rdata),
      .empty_o (fifo_empty)
   );

   always_comb begin
      arvalid_d  = arvalid_q;
      araddr_d   = araddr_q;
      ar_stale_d = ar_stale_q;
      tgt_d      = tgt_q;
      live_d     = live_q;
      stale_d    = stale_q;
      halted_d   = halted_q;
      word_d     = word_q;
      lane_d     = lane_q;
      valid_d    = valid_q;
      illegal_d  = illegal_q;
      pc_d       = pc_q;
      off_d      = off_q;
      first_d    = first_q;
      if (i_new_pc) begin
         stale_d   = stale_q + live_req + CW'(ar_hs) - CW'(drop);
         live_d    = '0;
         halted_d  = 1'b0;
         valid_d   = 1'b0;
         illegal_d = 1'b0;
         pc_d      = i_pc;
         off_d     = pc_lane;
         first_d   = 1'b1;
         // A stalled request must stay on the bus; the new target follows it.
         if (arvalid_q && !M_AXI_ARREADY) begin
            ar_stale_d = 1'b1;
            tgt_d      = pc_aligned;
         end else begin
            arvalid_d  = 1'b1;
            araddr_d   = pc_aligned;
            ar_stale_d = 1'b0;
         end
      end else begin
         if (M_AXI_RVALID && stale_q != '0) stale_d = stale_q - 1'b1;
         if (ar_hs) begin
            if (ar_stale_q) begin
               stale_d    = stale_d + 1'b1;
               araddr_d   = tgt_q;
               ar_stale_d = 1'b0;
            end else begin
               live_d   = live_q + 1'b1;
               araddr_d = araddr_q + AW'(DW/8);
            end
         end
         if (rd_en) live_d = live_d - 1'b1;
         if (accept) begin
            pc_d   = pc_q + AW'(IW/8);
            lane_d = lane_q + LW'(1);
            if (last_lane) valid_d = 1'b0;
         end
         if (load) begin
            word_d    = fifo_rdata[DW-1:0];
            lane_d    = first_q ? off_q : '0;
            first_d   = 1'b0;
            valid_d   = 1'b1;
            illegal_d = fifo_rdata[DW];
            if (fifo_rdata[DW]) halted_d = 1'b1;
         end
         if (!arvalid_q || ar_hs) arvalid_d = !halted_d && (live_d < DEPTH);
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (i_reset) begin
         arvalid_q  <= 1'b0;
         araddr_q   <= '0;
         ar_stale_q <= 1'b0;
         tgt_q      <= '0;
         live_q     <= '0;
         stale_q    <= '0;
         halted_q   <= 1'b1;
         word_q     <= '0;
         lane_q     <= '0;
         valid_q    <= 1'b0;
         illegal_q  <= 1'b0;
         pc_q       <= '0;
         off_q      <= '0;
         first_q    <= 1'b0;
      end else begin
         arvalid_q  <= arvalid_d;
         araddr_q   <= araddr_d;
         ar_stale_q <= ar_stale_d;
         tgt_q      <= tgt_d;
         live_q     <= live_d;
         stale_q    <= stale_d;
         halted_q   <= halted_d;
         word_q     <= word_d;
         lane_q     <= lane_d;
         valid_q    <= valid_d;
         illegal_q  <= illegal_d;
         pc_q       <= pc_d;
         off_q      <= off_d;
         first_q    <= first_d;
      end
   end

   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = ARPROT_INSN;
   assign M_AXI_RREADY  = 1'b1;
   assign o_valid       = valid_q;
   assign o_illegal     = illegal_q;
   assign o_pc          = pc_q;
   assign o_insn        = lanes[lane_q];

   logic unused_ok;
   assign unused_ok = &{1'b0, M_AXI_RRESP[0], fifo_full};

endmodule
